game_countdown_timer: RTL and testbench

GAME_COUNTDOWN_TIMER -- requirements
Module: game_countdown_timer

---
 rtl/game_countdown_timer.sv | 107 ++++++++++
 tb/tb_game_countdown_timer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/game_countdown_timer.sv
// Two-digit BCD countdown timer for a game clock, driven by an upstream 1 ms tick.
// state   | meaning
// IDLE    | after reset, digits 00, waiting for start
// RUN     | counting ms_tick, decrementing one second every MS_PER_SEC ticks
// PAUSED  | digits and ms_cnt frozen until pause drops
// EXPIRED | reached 00, holds until the next start
module game_countdown_timer #(
  parameter int MS_PER_SEC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ms_tick,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic       tick_enable,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       time_up
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] PAUSED  = 2'd2;
  localparam logic [1:0] EXPIRED = 2'd3;

  localparam logic [9:0] MS_LAST = 10'(MS_PER_SEC - 1);

  logic [1:0] state;
  logic [9:0] ms_cnt;

  logic [3:0] ld_tens, ld_ones;
  logic       ld_zero;
  logic [3:0] dec_tens, dec_ones;
  logic       dec_zero;

  always_comb begin
    ld_tens = (load_tens > 4'd9) ? 4'd9 : load_tens;
    ld_ones = (load_ones > 4'd9) ? 4'd9 : load_ones;
    ld_zero = (ld_tens == 4'd0) && (ld_ones == 4'd0);
  end

  // BCD borrow: ones wraps 0 -> 9 and takes one from tens
  always_comb begin
    dec_tens = sec_tens;
    dec_ones = sec_ones - 4'd1;
    if (sec_ones == 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = sec_tens - 4'd1;
    end
    dec_zero = (dec_tens == 4'd0) && (dec_ones == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ms_cnt   <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
      time_up  <= 1'b0;
    end else begin
      time_up <= 1'b0;
      if (start) begin
        sec_tens <= ld_tens;
        sec_ones <= ld_ones;
        ms_cnt   <= '0;
        if (ld_zero) begin
          state <= EXPIRED;
          // back-to-back zero loads must not stretch time_up past one cycle
          time_up <= ~time_up;
        end else begin
          state <= RUN;
        end
      end else begin
        case (state)
          RUN: begin
            if (pause) begin
              state <= PAUSED;
            end else if (ms_tick) begin
              if (ms_cnt == MS_LAST) begin
                ms_cnt   <= '0;
                sec_tens <= dec_tens;
                sec_ones <= dec_ones;
                if (dec_zero) begin
                  state   <= EXPIRED;
                  time_up <= 1'b1;
                end
              end else begin
                ms_cnt <= ms_cnt + 10'd1;
              end
            end
          end
          PAUSED: begin
            if (!pause) state <= RUN;
          end
          default: ;
        endcase
      end
    end
  end

  assign tick_enable = (state == RUN);
  assign running     = (state == RUN);

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for game_countdown_timer with MS_PER_SEC=4.
module tb_game_countdown_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ms_tick;
  logic       start;
  logic       pause;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic       tick_enable;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       time_up;

  int errs   = 0;
  int checks = 0;
  int tu_cnt;

  game_countdown_timer #(.MS_PER_SEC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ms_tick    (ms_tick),
    .start      (start),
    .pause      (pause),
    .load_tens  (load_tens),
    .load_ones  (load_ones),
    .tick_enable(tick_enable),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .running    (running),
    .time_up    (time_up)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] t, input logic [3:0] o);
    load_tens = t;
    load_ones = o;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic ticks(input int n);
    ms_tick = 1'b1;
    repeat (n) step();
    ms_tick = 1'b0;
  endtask

  function automatic int digits();
    return sec_tens * 10 + sec_ones;
  endfunction

  initial begin
    rst = 1'b0; ms_tick = 1'b1; start = 1'b1; pause = 1'b0;
    load_tens = 4'd5; load_ones = 4'd5;
    step();
    step();
    chk("reset_state", dut.state, 0);
    chk("reset_digits", digits(), 0);
    chk("reset_outs", {tick_enable, running, time_up}, 0);
    rst = 1'b1; start = 1'b0; ms_tick = 1'b0;
    step();
    chk("idle_hold", dut.state, 0);

    // 05 countdown over 20 ticks
    do_start(4'd0, 4'd5);
    chk("run05_state", dut.state, 1);
    chk("run05_digits", digits(), 5);
    chk("run05_enable", {tick_enable, running}, 3);
    ms_tick = 1'b1;
    tu_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (time_up) tu_cnt++;
      if (i % 4 == 0) chk($sformatf("cd05_t%0d", i), digits(), 5 - i / 4);
      if (i == 20) chk("cd05_timeup_edge", time_up, 1);
    end
    chk("cd05_timeup_count", tu_cnt, 1);
    chk("cd05_state", dut.state, 3);
    step();
    ms_tick = 1'b0;
    chk("cd05_trailing_tick", digits(), 0);
    chk("cd05_enable_off", {tick_enable, running, time_up}, 0);

    // 10 borrow to 09 then to 00
    do_start(4'd1, 4'd0);
    ticks(4);
    chk("borrow_09", digits(), 9);
    ms_tick = 1'b1;
    tu_cnt = 0;
    for (int i = 1; i <= 36; i++) begin
      step();
      if (time_up) tu_cnt++;
      if (i == 35) chk("borrow_t35", digits(), 1);
    end
    ms_tick = 1'b0;
    chk("borrow_00", digits(), 0);
    chk("borrow_timeup_count", tu_cnt, 1);
    step();
    chk("borrow_timeup_clear", time_up, 0);

    // pause with coincident tick at ms_cnt=2
    do_start(4'd0, 4'd5);
    ticks(2);
    chk("pause_pre_cnt", dut.ms_cnt, 2);
    pause = 1'b1; ms_tick = 1'b1;
    step();
    chk("pause_state", dut.state, 2);
    chk("pause_cnt_drop", dut.ms_cnt, 2);
    chk("pause_enable", tick_enable, 0);
    step(); step();
    chk("pause_hold_cnt", dut.ms_cnt, 2);
    chk("pause_hold_digits", digits(), 5);
    pause = 1'b0; ms_tick = 1'b0;
    step();
    chk("pause_resume", dut.state, 1);
    ticks(1);
    chk("pause_mid", digits(), 5);
    ticks(1);
    chk("pause_dec", digits(), 4);
    chk("pause_cnt_wrap", dut.ms_cnt, 0);

    // zero load and clamp
    do_start(4'd0, 4'd0);
    chk("zero_state", dut.state, 3);
    chk("zero_timeup", time_up, 1);
    step();
    chk("zero_timeup_one", time_up, 0);
    load_tens = 4'd0; load_ones = 4'd0; start = 1'b1;
    step();
    chk("zero_again_timeup", time_up, 1);
    step();
    chk("zero_b2b_timeup", time_up, 0);
    start = 1'b0;
    step();
    do_start(4'd12, 4'd15);
    chk("clamp_digits", digits(), 99);
    chk("clamp_running", running, 1);

    // start from EXPIRED, then reload mid-run with pause and tick asserted
    do_start(4'd0, 4'd0);
    step();
    do_start(4'd0, 4'd3);
    chk("exp_start_state", dut.state, 1);
    chk("exp_start_digits", digits(), 3);
    ticks(1);
    chk("reload_pre_cnt", dut.ms_cnt, 1);
    pause = 1'b1; ms_tick = 1'b1;
    do_start(4'd2, 4'd0);
    pause = 1'b0; ms_tick = 1'b0;
    chk("reload_digits", digits(), 20);
    chk("reload_cnt", dut.ms_cnt, 0);
    chk("reload_state", dut.state, 1);
    chk("reload_timeup", time_up, 0);

    // mid-count reset at 07
    do_start(4'd0, 4'd7);
    ticks(2);
    rst = 1'b0; ms_tick = 1'b1;
    step();
    rst = 1'b1;
    chk("midrst_outs", {tick_enable, running, time_up, sec_tens, sec_ones}, 0);
    chk("midrst_state", dut.state, 0);
    step();
    ms_tick = 1'b0;
    chk("midrst_tick_ignored", dut.ms_cnt, 0);
    chk("midrst_idle", dut.state, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
